// File: rtl/model_dnc_pkg.sv
// Shared DNC definitions: FSM encodings, constants and size-legality helper.
package model_dnc_pkg;

    localparam int DNC_DATA_SIZE    = 64;
    localparam int DNC_CONTROL_SIZE = 64;

    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        CAPTURE_STATE = 2'd1,
        EMIT_STATE    = 2'd2
    } state_t;

    // A size is unusable when zero or larger than the buffer dimension.
    function automatic logic size_illegal(input logic [63:0] size, input logic [63:0] max);
        return (size == ZERO_DATA) || (size > max);
    endfunction

endpackage

// File: rtl/model_read_keys_if.sv
// Control and key-element stream bundle between the read-key producer and its environment.
interface model_read_keys_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 ERROR;
    logic                 K_IN_ENABLE;
    logic                 K_OUT_I_ENABLE;
    logic                 K_OUT_K_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_R_IN;
    logic [DATA_SIZE-1:0] SIZE_W_IN;
    logic [DATA_SIZE-1:0] K_IN;
    logic [DATA_SIZE-1:0] K_OUT;

    modport master (
        output START, K_IN_ENABLE, SIZE_R_IN, SIZE_W_IN, K_IN,
        input  READY, ERROR, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
    );

    modport slave (
        input  START, K_IN_ENABLE, SIZE_R_IN, SIZE_W_IN, K_IN,
        output READY, ERROR, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
    );
endinterface

// File: rtl/model_key_buffer.sv
// Key matrix storage: synchronous write port, combinational read port, contents never reset.
module model_key_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 CLK,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem_r [DEPTH];

    // Element write
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/model_read_keys.sv
// Read-head key buffer: captures an R x W key matrix element by element, then
// replays it back-to-back with row/element enables.
module model_read_keys
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_R        = 4,
    parameter int MAX_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    model_read_keys_if.slave bus
);

    localparam int DEPTH  = MAX_R * MAX_W;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                  state_r, state_s;
    logic [CONTROL_SIZE-1:0] i_r, i_s, k_r, k_s;
    logic [CONTROL_SIZE-1:0] adv_i_s, adv_k_s;
    logic [DATA_SIZE-1:0]    size_r_r, size_r_s, size_w_r, size_w_s;
    logic [DATA_SIZE-1:0]    k_out_r, k_out_s;
    logic                    ready_r, ready_s, error_r, error_s;
    logic                    i_en_r, i_en_s, k_en_r, k_en_s;
    logic                    wr_en_s, col_last_s, last_s, bad_size_s;
    logic [ADDR_W-1:0]       addr_s;
    logic [DATA_SIZE-1:0]    rd_data_s;

    // Row-major address i*MAX_W+k shared by capture writes and emit reads
    assign addr_s = ADDR_W'(i_r) * ADDR_W'(MAX_W) + ADDR_W'(k_r);

    assign col_last_s = (k_r == CONTROL_SIZE'(size_w_r - DATA_SIZE'(ONE_DATA)));
    assign last_s     = col_last_s && (i_r == CONTROL_SIZE'(size_r_r - DATA_SIZE'(ONE_DATA)));
    assign adv_k_s    = col_last_s ? CONTROL_SIZE'(ZERO_CONTROL) : k_r + CONTROL_SIZE'(ONE_CONTROL);
    assign adv_i_s    = col_last_s ? i_r + CONTROL_SIZE'(ONE_CONTROL) : i_r;
    assign bad_size_s = size_illegal(64'(bus.SIZE_R_IN), 64'(MAX_R)) ||
                        size_illegal(64'(bus.SIZE_W_IN), 64'(MAX_W));

    model_key_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_buffer (
        .CLK     (CLK),
        .wr_en   (wr_en_s),
        .wr_addr (addr_s),
        .wr_data (bus.K_IN),
        .rd_addr (addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, counter and output computation
    always_comb begin
        state_s  = state_r;
        i_s      = i_r;
        k_s      = k_r;
        size_r_s = size_r_r;
        size_w_s = size_w_r;
        k_out_s  = k_out_r;
        ready_s  = EMPTY;
        error_s  = EMPTY;
        i_en_s   = EMPTY;
        k_en_s   = EMPTY;
        wr_en_s  = EMPTY;
        case (state_r)
            STARTER_STATE: begin
                if (bus.START) begin
                    size_r_s = bus.SIZE_R_IN;
                    size_w_s = bus.SIZE_W_IN;
                    i_s      = CONTROL_SIZE'(ZERO_CONTROL);
                    k_s      = CONTROL_SIZE'(ZERO_CONTROL);
                    if (bad_size_s) begin
                        error_s = FULL;
                        ready_s = FULL;
                        state_s = STARTER_STATE;
                    end else begin
                        state_s = CAPTURE_STATE;
                    end
                end else begin
                    state_s = STARTER_STATE;
                end
            end
            CAPTURE_STATE: begin
                if (bus.K_IN_ENABLE) begin
                    wr_en_s = FULL;
                    if (last_s) begin
                        i_s     = CONTROL_SIZE'(ZERO_CONTROL);
                        k_s     = CONTROL_SIZE'(ZERO_CONTROL);
                        state_s = EMIT_STATE;
                    end else begin
                        i_s = adv_i_s;
                        k_s = adv_k_s;
                    end
                end else begin
                    state_s = CAPTURE_STATE;
                end
            end
            EMIT_STATE: begin
                k_out_s = rd_data_s;
                k_en_s  = FULL;
                i_en_s  = (k_r == CONTROL_SIZE'(ZERO_CONTROL));
                if (last_s) begin
                    i_s     = CONTROL_SIZE'(ZERO_CONTROL);
                    k_s     = CONTROL_SIZE'(ZERO_CONTROL);
                    ready_s = FULL;
                    state_s = STARTER_STATE;
                end else begin
                    i_s = adv_i_s;
                    k_s = adv_k_s;
                end
            end
            default: begin
                state_s = STARTER_STATE;
            end
        endcase
    end

    // State, counters, latched sizes and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= STARTER_STATE;
            i_r      <= CONTROL_SIZE'(ZERO_CONTROL);
            k_r      <= CONTROL_SIZE'(ZERO_CONTROL);
            size_r_r <= DATA_SIZE'(ZERO_DATA);
            size_w_r <= DATA_SIZE'(ZERO_DATA);
            k_out_r  <= DATA_SIZE'(ZERO_DATA);
            ready_r  <= EMPTY;
            error_r  <= EMPTY;
            i_en_r   <= EMPTY;
            k_en_r   <= EMPTY;
        end else begin
            state_r  <= state_s;
            i_r      <= i_s;
            k_r      <= k_s;
            size_r_r <= size_r_s;
            size_w_r <= size_w_s;
            k_out_r  <= k_out_s;
            ready_r  <= ready_s;
            error_r  <= error_s;
            i_en_r   <= i_en_s;
            k_en_r   <= k_en_s;
        end
    end

    assign bus.K_OUT          = k_out_r;
    assign bus.READY          = ready_r;
    assign bus.ERROR          = error_r;
    assign bus.K_OUT_I_ENABLE = i_en_r;
    assign bus.K_OUT_K_ENABLE = k_en_r;

endmodule

// File: tb/tb_model_read_keys.sv
// Scoreboard bench for model_read_keys: stimulus queues expected output events,
// a negedge monitor pops and compares every cycle the DUT shows activity.
module tb_model_read_keys;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   last_cyc = 0;

    typedef struct {
        logic [63:0] data;
        logic        k_en;
        logic        i_en;
        logic        ready;
        logic        error;
        int          exp_cyc;
        bit          chain;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    model_read_keys_if #(.DATA_SIZE(64)) bus ();

    model_read_keys #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (64),
        .MAX_R        (4),
        .MAX_W        (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle with any output activity must match the next expected event
    always @(negedge CLK) begin
        if (!RST && (bus.K_OUT_K_ENABLE || bus.K_OUT_I_ENABLE || bus.READY || bus.ERROR)) begin
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_output: k_en=%b i_en=%b ready=%b error=%b k_out=%0d expected none (cyc %0d)",
                         bus.K_OUT_K_ENABLE, bus.K_OUT_I_ENABLE, bus.READY, bus.ERROR, bus.K_OUT, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("flags{k_en,i_en,ready,error}",
                    64'({bus.K_OUT_K_ENABLE, bus.K_OUT_I_ENABLE, bus.READY, bus.ERROR}),
                    64'({mon_e.k_en, mon_e.i_en, mon_e.ready, mon_e.error}));
                if (mon_e.k_en) chk("k_out", bus.K_OUT, mon_e.data);
                if (mon_e.exp_cyc >= 0) chk("latency_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
                else if (mon_e.chain) chk("contiguous_cycle", 64'(cyc), 64'(last_cyc + 1));
                last_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_txn(input logic [63:0] r, input logic [63:0] w);
        bus.START     = 1'b1;
        bus.SIZE_R_IN = r;
        bus.SIZE_W_IN = w;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    // Drive an R x W matrix base..base+R*W-1; expectations are queued with the last element
    task automatic send_all(input int r, input int w, input logic [63:0] base,
                            input bit gap, input bit hold_start);
        exp_t e;
        for (int n = 0; n < r * w; n++) begin
            if (n == r * w - 1) begin
                for (int m = 0; m < r * w; m++) begin
                    e.data    = base + 64'(m);
                    e.k_en    = 1'b1;
                    e.i_en    = ((m % w) == 0);
                    e.ready   = (m == r * w - 1);
                    e.error   = 1'b0;
                    e.exp_cyc = (m == 0) ? cyc + 2 : -1;
                    e.chain   = (m != 0);
                    q.push_back(e);
                end
                if (hold_start) bus.START = 1'b1;
            end
            bus.K_IN        = base + 64'(n);
            bus.K_IN_ENABLE = 1'b1;
            @(posedge CLK);
            #1;
            bus.K_IN_ENABLE = 1'b0;
            if (gap && (n != r * w - 1)) idle(2);
        end
    endtask

    task automatic bad_start(input logic [63:0] r, input logic [63:0] w);
        exp_t e;
        e.data    = 64'd0;
        e.k_en    = 1'b0;
        e.i_en    = 1'b0;
        e.ready   = 1'b1;
        e.error   = 1'b1;
        e.exp_cyc = cyc + 1;
        e.chain   = 1'b0;
        q.push_back(e);
        start_txn(r, w);
        idle(3);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0) && (n < 300)) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events outstanding expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_k_out"}, bus.K_OUT, 64'd0);
        chk({tag, "_ready"}, 64'(bus.READY), 64'd0);
        chk({tag, "_error"}, 64'(bus.ERROR), 64'd0);
        chk({tag, "_i_en"}, 64'(bus.K_OUT_I_ENABLE), 64'd0);
        chk({tag, "_k_en"}, 64'(bus.K_OUT_K_ENABLE), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.START       = 1'b0;
        bus.K_IN_ENABLE = 1'b0;
        bus.SIZE_R_IN   = 64'd0;
        bus.SIZE_W_IN   = 64'd0;
        bus.K_IN        = 64'd0;
        idle(3);
        check_quiet_outputs("reset");
        RST = 1'b0;
        idle(2);

        // 1: R=2 W=3, back-to-back 1..6
        start_txn(64'd2, 64'd3);
        send_all(2, 3, 64'd1, 1'b0, 1'b0);
        wait_drain();
        idle(2);

        // 2: same sizes with enable gaps
        start_txn(64'd2, 64'd3);
        send_all(2, 3, 64'd1, 1'b1, 1'b0);
        wait_drain();
        idle(2);

        // 4: illegal sizes W=0, then R=5
        bad_start(64'd2, 64'd0);
        bad_start(64'd5, 64'd3);

        // 3: R=1 W=1 single element
        start_txn(64'd1, 64'd1);
        send_all(1, 1, 64'hA5, 1'b0, 1'b0);
        wait_drain();
        idle(3);

        // 5: abort mid-capture with reset, then full 4x8 matrix
        start_txn(64'd4, 64'd8);
        for (int n = 0; n < 10; n++) begin
            bus.K_IN        = 64'(n);
            bus.K_IN_ENABLE = 1'b1;
            @(posedge CLK);
            #1;
        end
        bus.K_IN_ENABLE = 1'b0;
        RST = 1'b1;
        idle(2);
        check_quiet_outputs("abort_reset");
        RST = 1'b0;
        idle(4);
        check_quiet_outputs("after_abort");
        start_txn(64'd4, 64'd8);
        send_all(4, 8, 64'd100, 1'b0, 1'b0);
        wait_drain();
        idle(2);

        // 6: START held through EMIT; next transaction launches from STARTER
        start_txn(64'd2, 64'd2);
        send_all(2, 2, 64'd200, 1'b0, 1'b1);
        wait_drain();
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        send_all(2, 2, 64'd300, 1'b0, 1'b0);
        wait_drain();
        idle(4);

        chk("queue_empty_at_end", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
